// File: rtl/bpu_redirect_ctrl.sv
// Branch-redirect scheduler: predicts CALL/PCR/RET targets, waits out the MIPS
// delay slot, then presents a single redirect to the PC generator.

`ifndef TYPE_NUL
`define TYPE_NUL  2'd0
`define TYPE_CALL 2'd1
`define TYPE_PCR  2'd2
`define TYPE_RET  2'd3
`endif

module bpu_redirect_ctrl #(
    parameter int RAS_DEPTH = 8,
    parameter int RAS_PTR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_valid,
    output logic                 fetch_ready,
    input  logic [31:0]          fetch_pc,
    input  logic [1:0]           inst_type,
    input  logic [31:0]          inst_offset,
    input  logic                 inst_link,
    input  logic                 ex_flush,
    output logic                 redir_valid,
    input  logic                 redir_ready,
    output logic [31:0]          redir_pc,
    output logic [RAS_PTR_W:0]   ras_count
);

    typedef enum logic [1:0] {IDLE, DS_WAIT, REDIR} state_t;

    localparam logic [RAS_PTR_W:0] RAS_FULL_CNT = RAS_DEPTH[RAS_PTR_W:0];

    state_t                state;
    logic [31:0]           ras [RAS_DEPTH];
    logic [RAS_PTR_W-1:0]  ras_ptr;

    logic                  fire;
    logic                  idle_fire;
    logic [31:0]           pc_plus4;
    logic [31:0]           pc_plus8;
    logic [31:0]           ras_top;
    logic                  ras_nonempty;
    logic                  ras_full;
    logic                  predict_taken;
    logic [31:0]           predict_target;
    logic                  do_push;
    logic                  do_pop;

    assign fetch_ready  = (state != REDIR);
    assign fire         = fetch_valid & fetch_ready;
    // A fire that coincides with a flush is dropped entirely.
    assign idle_fire    = fire & (state == IDLE) & ~ex_flush;
    assign pc_plus4     = fetch_pc + 32'd4;
    assign pc_plus8     = fetch_pc + 32'd8;
    assign ras_top      = ras[ras_ptr - 1'b1];
    assign ras_nonempty = (ras_count != '0);
    assign ras_full     = (ras_count == RAS_FULL_CNT);

    always_comb begin
        predict_taken  = 1'b0;
        predict_target = '0;
        do_push        = 1'b0;
        do_pop         = 1'b0;
        case (inst_type)
            `TYPE_CALL: begin
                predict_taken  = 1'b1;
                predict_target = {pc_plus4[31:28], inst_offset[27:0]};
                do_push        = inst_link;
            end
            `TYPE_PCR: begin
                predict_taken  = inst_offset[31];
                predict_target = pc_plus4 + inst_offset;
                do_push        = inst_link;
            end
            `TYPE_RET: begin
                predict_taken  = ras_nonempty;
                predict_target = ras_top;
                do_pop         = ras_nonempty;
            end
            default: begin
                predict_taken  = 1'b0;
            end
        endcase
        if (!idle_fire) begin
            predict_taken = 1'b0;
            do_push       = 1'b0;
            do_pop        = 1'b0;
        end
    end

    // Entry contents need no reset; the pointer and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            ras[ras_ptr] <= pc_plus8;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            ras_ptr     <= '0;
            ras_count   <= '0;
        end else if (ex_flush) begin
            state       <= IDLE;
            redir_valid <= 1'b0;
        end else begin
            if (do_push) begin
                ras_ptr <= ras_ptr + 1'b1;
                if (!ras_full) begin
                    ras_count <= ras_count + 1'b1;
                end
            end else if (do_pop) begin
                ras_ptr   <= ras_ptr - 1'b1;
                ras_count <= ras_count - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (predict_taken) begin
                        redir_pc <= predict_target;
                        state    <= DS_WAIT;
                    end
                end
                DS_WAIT: begin
                    if (fire) begin
                        redir_valid <= 1'b1;
                        state       <= REDIR;
                    end
                end
                REDIR: begin
                    if (redir_ready) begin
                        redir_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    redir_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bpu_redirect_ctrl.sv
// Scoreboard bench for bpu_redirect_ctrl: a queue-based reference model predicts
// redirects and RAS occupancy; a negedge monitor compares the DUT against it.

`ifndef TYPE_NUL
`define TYPE_NUL  2'd0
`define TYPE_CALL 2'd1
`define TYPE_PCR  2'd2
`define TYPE_RET  2'd3
`endif

module tb_bpu_redirect_ctrl;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [1:0]  inst_type;
    logic [31:0] inst_offset;
    logic        inst_link;
    logic        ex_flush;
    logic        redir_valid;
    logic        redir_ready;
    logic [31:0] redir_pc;
    logic [3:0]  ras_count;

    bpu_redirect_ctrl #(.RAS_DEPTH(DEPTH), .RAS_PTR_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_pc    (fetch_pc),
        .inst_type   (inst_type),
        .inst_offset (inst_offset),
        .inst_link   (inst_link),
        .ex_flush    (ex_flush),
        .redir_valid (redir_valid),
        .redir_ready (redir_ready),
        .redir_pc    (redir_pc),
        .ras_count   (ras_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: phase of the redirect protocol, RAS as a bounded queue.
    typedef enum {M_IDLE, M_DS, M_REDIR} phase_e;
    phase_e      m_phase;
    logic [31:0] m_pend;
    logic [31:0] ras_q[$];
    logic [31:0] exp_q[$];
    bit          m_ok = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic model_update();
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] pc4;
        if (rst) begin
            m_phase = M_IDLE;
            ras_q.delete();
            exp_q.delete();
            m_ok = 1;
        end else if (ex_flush) begin
            m_phase = M_IDLE;
            exp_q.delete();
        end else begin
            case (m_phase)
                M_IDLE: if (fetch_valid) begin
                    taken = 0;
                    tgt   = 0;
                    pc4   = fetch_pc + 4;
                    if (inst_type == `TYPE_CALL) begin
                        taken = 1;
                        tgt   = {pc4[31:28], inst_offset[27:0]};
                    end else if (inst_type == `TYPE_PCR) begin
                        taken = inst_offset[31];
                        tgt   = pc4 + inst_offset;
                    end else if (inst_type == `TYPE_RET && ras_q.size() > 0) begin
                        taken = 1;
                        tgt   = ras_q.pop_back();
                    end
                    if (inst_link && (inst_type == `TYPE_CALL || inst_type == `TYPE_PCR)) begin
                        ras_q.push_back(fetch_pc + 8);
                        if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
                    end
                    if (taken) begin
                        m_pend  = tgt;
                        m_phase = M_DS;
                    end
                end
                M_DS: if (fetch_valid) begin
                    exp_q.push_back(m_pend);
                    m_phase = M_REDIR;
                end
                M_REDIR: if (redir_ready) m_phase = M_IDLE;
                default: m_phase = M_IDLE;
            endcase
        end
    endtask

    // Drive one cycle of inputs, then advance the model across the clock edge.
    task automatic apply_stimulus(input logic fv, input logic [31:0] pc, input logic [1:0] ty,
                                  input logic [31:0] off, input logic lnk, input logic fl,
                                  input logic rdy, input logic rs);
        fetch_valid = fv;
        fetch_pc    = pc;
        inst_type   = ty;
        inst_offset = off;
        inst_link   = lnk;
        ex_flush    = fl;
        redir_ready = rdy;
        rst         = rs;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_cycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, `TYPE_NUL, 0, 0, 0, rdy, 0);
    endtask

    task automatic branch_with_slot(input logic [31:0] pc, input logic [1:0] ty,
                                    input logic [31:0] off, input logic lnk);
        apply_stimulus(1, pc, ty, off, lnk, 0, 0, 0);
        apply_stimulus(1, pc + 4, `TYPE_NUL, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, `TYPE_NUL, 0, 0, 0, 1, 0);
    endtask

    // Monitor: compare DUT state against the model and pop on redirect handshakes.
    always @(negedge clk) begin
        if (m_ok) begin
            check_output("fetch_ready", {31'd0, fetch_ready}, {31'd0, m_phase != M_REDIR});
            check_output("redir_valid", {31'd0, redir_valid}, {31'd0, m_phase == M_REDIR});
            check_output("ras_count", {28'd0, ras_count}, ras_q.size());
            if (redir_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL redir_unexpected: got pc 0x%08h, expected no redirect", redir_pc);
                end else begin
                    check_output("redir_pc", redir_pc, exp_q[0]);
                    if (redir_ready && !ex_flush && !rst) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [1:0]  ty;
        logic [31:0] off;
        apply_stimulus(1, 32'h100, `TYPE_CALL, 32'h40, 1, 0, 0, 1);
        apply_stimulus(1, 32'h100, `TYPE_CALL, 32'h40, 1, 0, 0, 1);
        idle_cycles(1, 0);

        // JAL with a stalled PC generator, then the matching return.
        apply_stimulus(1, 32'h8000_1000, `TYPE_CALL, 32'h0000_0400, 1, 0, 0, 0);
        apply_stimulus(1, 32'h8000_1004, `TYPE_NUL, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(1, 32'h8000_0400, `TYPE_RET, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, `TYPE_NUL, 0, 0, 0, 1, 0);
        branch_with_slot(32'h8000_0500, `TYPE_RET, 0, 0);
        branch_with_slot(32'h8000_0600, `TYPE_RET, 0, 0);

        branch_with_slot(32'h0000_1000, `TYPE_PCR, 32'hFFFF_FFF0, 0);
        branch_with_slot(32'h0000_2000, `TYPE_PCR, 32'h0000_0010, 0);

        // Overflow the RAS with nine linking calls, then unwind it.
        for (int i = 1; i <= 9; i++) branch_with_slot(32'h4000_0000 + i * 32'h100, `TYPE_CALL, 32'h0100_0000, 1);
        for (int i = 0; i < 9; i++) branch_with_slot(32'h5000_0000 + i * 32'h10, `TYPE_RET, 0, 0);

        // Flushes in DS_WAIT, in a stalled REDIR, and on a fire.
        apply_stimulus(1, 32'h6000_0000, `TYPE_CALL, 32'h20, 1, 0, 0, 0);
        apply_stimulus(1, 32'h6000_0004, `TYPE_NUL, 0, 0, 1, 0, 0);
        idle_cycles(1, 0);
        apply_stimulus(1, 32'h6000_0100, `TYPE_CALL, 32'h20, 1, 0, 0, 0);
        apply_stimulus(1, 32'h6000_0104, `TYPE_NUL, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, `TYPE_NUL, 0, 0, 1, 0, 0);
        idle_cycles(1, 0);
        apply_stimulus(1, 32'h6000_0200, `TYPE_CALL, 32'h20, 1, 1, 0, 0);
        apply_stimulus(1, 32'h6000_0300, `TYPE_RET, 0, 0, 1, 0, 0);
        idle_cycles(2, 1);

        for (int c = 0; c < 4000; c++) begin
            ty  = 2'($urandom_range(0, 3));
            off = $urandom();
            if (ty == `TYPE_PCR) off = ($urandom_range(0, 1) != 0) ? -($urandom_range(4, 4096)) : $urandom_range(4, 4096);
            apply_stimulus($urandom_range(0, 3) != 0, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, ty, off,
                           $urandom_range(0, 1) != 0, $urandom_range(0, 40) == 0,
                           $urandom_range(0, 1) != 0, $urandom_range(0, 300) == 0);
        end
        idle_cycles(4, 1);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
